// File: rtl/hci_bank_ts_arbiter.sv
// rtl/hci_bank_ts_arbiter.sv - per-bank HCI arbiter with atomic test-and-set sequencing
module hci_bank_ts_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int BW    = 8,
  parameter int IW    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    arb_policy_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*AW-1:0]     add_i,
  input  logic [N_REQ-1:0]        wen_i,
  input  logic [N_REQ*DW-1:0]     wdata_i,
  input  logic [N_REQ*DW/BW-1:0]  be_i,
  input  logic [N_REQ-1:0]        ts_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        r_valid_o,
  output logic [DW-1:0]           r_data_o,
  output logic                    mem_req_o,
  output logic [AW-1:0]           mem_add_o,
  output logic                    mem_wen_o,
  output logic [DW-1:0]           mem_wdata_o,
  output logic [DW/BW-1:0]        mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic [DW-1:0]           mem_r_data_i,
  output logic [IW-1:0]           winner_o
);

  localparam int BEW = DW / BW;

  typedef enum logic {
    IDLE  = 1'b0,
    TS_WR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   ts_add_q, ts_add_d;
  logic [IW-1:0]   ts_idx_q, ts_idx_d;
  logic            resp_pending_q, resp_pending_d;
  logic [IW-1:0]   resp_idx_q, resp_idx_d;

  logic            any_req;
  logic [IW-1:0]   winner;
  logic [IW:0]     cand;

  // Pick the winner: scan from rr_ptr with wrap (round-robin) or from index 0 (fixed priority)
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_policy_i) begin
        cand = (IW+1)'(i);
      end else begin
        cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
        if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      end
      if (!any_req && req_i[cand]) begin
        any_req = 1'b1;
        winner  = cand[IW-1:0];
      end
    end
  end

  // Sequencer: IDLE forwards the winner to the bank, TS_WR locks the bank for the all-ones write
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    ts_add_d       = ts_add_q;
    ts_idx_d       = ts_idx_q;
    resp_pending_d = 1'b0;
    resp_idx_d     = resp_idx_q;
    gnt_o          = '0;
    mem_req_o      = 1'b0;
    mem_add_o      = '0;
    mem_wen_o      = 1'b0;
    mem_wdata_o    = '0;
    mem_be_o       = '0;
    winner_o       = '0;
    unique case (state_q)
      IDLE: begin
        winner_o = winner;
        if (any_req) begin
          mem_req_o     = 1'b1;
          mem_add_o     = add_i[int'(winner)*AW +: AW];
          mem_wen_o     = wen_i[winner];
          mem_wdata_o   = wdata_i[int'(winner)*DW +: DW];
          mem_be_o      = be_i[int'(winner)*BEW +: BEW];
          gnt_o[winner] = mem_gnt_i;
          if (mem_gnt_i) begin
            resp_pending_d = 1'b1;
            resp_idx_d     = winner;
            if (!arb_policy_i) begin
              rr_ptr_d = (winner == IW'(N_REQ-1)) ? '0 : winner + IW'(1);
            end
            if (ts_i[winner] && wen_i[winner]) begin
              ts_add_d = add_i[int'(winner)*AW +: AW];
              ts_idx_d = winner;
              state_d  = TS_WR;
            end
          end
        end
      end
      TS_WR: begin
        winner_o    = ts_idx_q;
        mem_req_o   = 1'b1;
        mem_wen_o   = 1'b0;
        mem_add_o   = ts_add_q;
        mem_wdata_o = '1;
        mem_be_o    = '1;
        if (mem_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // While reset is held the bank and requesters see a quiet interface
    if (!rst_ni) begin
      gnt_o     = '0;
      mem_req_o = 1'b0;
      winner_o  = '0;
    end
  end

  // Return path: one-hot valid for the requester granted last cycle, data straight from the bank
  always_comb begin
    r_valid_o = '0;
    if (resp_pending_q) r_valid_o[resp_idx_q] = 1'b1;
    r_data_o = mem_r_data_i;
  end

  // State registers; reset abandons any pending test-and-set write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      ts_add_q       <= '0;
      ts_idx_q       <= '0;
      resp_pending_q <= 1'b0;
      resp_idx_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      ts_add_q       <= ts_add_d;
      ts_idx_q       <= ts_idx_d;
      resp_pending_q <= resp_pending_d;
      resp_idx_q     <= resp_idx_d;
    end
  end

endmodule

// File: tb/tb_hci_bank_ts_arbiter.sv
// tb/tb_hci_bank_ts_arbiter.sv - self-checking bench for hci_bank_ts_arbiter
module tb_hci_bank_ts_arbiter;
  localparam int N   = 4;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int BW  = 8;
  localparam int IW  = 2;
  localparam int BEW = DW / BW;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              arb_policy_i = 1'b0;
  logic [N-1:0]      req_i = '0;
  logic [N*AW-1:0]   add_i = '0;
  logic [N-1:0]      wen_i = '0;
  logic [N*DW-1:0]   wdata_i = '0;
  logic [N*BEW-1:0]  be_i = '0;
  logic [N-1:0]      ts_i = '0;
  logic [N-1:0]      gnt_o;
  logic [N-1:0]      r_valid_o;
  logic [DW-1:0]     r_data_o;
  logic              mem_req_o;
  logic [AW-1:0]     mem_add_o;
  logic              mem_wen_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [BEW-1:0]    mem_be_o;
  logic              mem_gnt_i = 1'b0;
  logic [DW-1:0]     mem_r_data_i = '0;
  logic [IW-1:0]     winner_o;

  int tests = 0;
  int failed = 0;

  // Bank storage driven only by the DUT's memory port
  logic [DW-1:0] bank [0:(1<<AW)-1];
  // Reference storage updated only by the model
  logic [DW-1:0] refmem [0:(1<<AW)-1];

  // Reference state
  int            m_ptr;
  bit            m_ts;
  logic [AW-1:0] m_ts_add;
  bit            m_pend;
  bit            m_pend_rd;
  int            m_pidx;
  logic [DW-1:0] m_exp_rdata;
  bit            e_any;
  int            e_w;

  hci_bank_ts_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .BW(BW), .IW(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .arb_policy_i(arb_policy_i),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i),
    .be_i(be_i), .ts_i(ts_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_data_o(r_data_o), .mem_req_o(mem_req_o), .mem_add_o(mem_add_o),
    .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_r_data_i(mem_r_data_i), .winner_o(winner_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-port SRAM with 1-cycle read latency
  always @(posedge clk_i) begin
    if (mem_req_o && mem_gnt_i) begin
      if (mem_wen_o) mem_r_data_i <= bank[mem_add_o];
      else begin
        for (int b = 0; b < BEW; b++)
          if (mem_be_o[b]) bank[mem_add_o][b*BW +: BW] <= mem_wdata_o[b*BW +: BW];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rq(input int i, input bit r, input bit w, input bit t,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] b);
    req_i[i] = r;
    wen_i[i] = w;
    ts_i[i]  = t;
    add_i[i*AW +: AW]    = a;
    wdata_i[i*DW +: DW]  = d;
    be_i[i*BEW +: BEW]   = b;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ts = 0; m_pend = 0; m_pend_rd = 0; m_pidx = 0;
  endtask

  task automatic model_expect();
    e_any = 0;
    e_w = 0;
    if (!m_ts) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = arb_policy_i ? k : (m_ptr + k) % N;
        if (!e_any && req_i[idx]) begin
          e_any = 1;
          e_w = idx;
        end
      end
    end
  endtask

  task automatic model_update();
    bit hs;
    logic [AW-1:0] a;
    hs = !m_ts && e_any && mem_gnt_i;
    if (m_ts && mem_gnt_i) begin
      refmem[m_ts_add] = '1;
      m_ts = 0;
    end
    m_pend = hs;
    if (hs) begin
      a = add_i[e_w*AW +: AW];
      m_pidx = e_w;
      m_pend_rd = wen_i[e_w];
      if (wen_i[e_w]) m_exp_rdata = refmem[a];
      else begin
        for (int b = 0; b < BEW; b++)
          if (be_i[e_w*BEW + b]) refmem[a][b*BW +: BW] = wdata_i[e_w*DW + b*BW +: BW];
      end
      if (!arb_policy_i) m_ptr = (e_w + 1) % N;
      if (ts_i[e_w] && wen_i[e_w]) begin
        m_ts = 1;
        m_ts_add = a;
      end
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, return just after it
  task automatic cyc(input string tag, input int xg = -1, input int xv = -1, input longint xd = -1);
    @(negedge clk_i);
    model_expect();
    chk({tag, "/gnt"}, gnt_o, (!m_ts && e_any && mem_gnt_i) ? (64'd1 << e_w) : 64'd0);
    chk({tag, "/rvalid"}, r_valid_o, m_pend ? (64'd1 << m_pidx) : 64'd0);
    chk({tag, "/mem_req"}, mem_req_o, m_ts || e_any);
    if (m_ts) begin
      chk({tag, "/ts_add"}, mem_add_o, m_ts_add);
      chk({tag, "/ts_wen"}, mem_wen_o, 0);
      chk({tag, "/ts_wdata"}, mem_wdata_o, 64'hFFFF_FFFF);
      chk({tag, "/ts_be"}, mem_be_o, 64'hF);
    end else if (e_any) begin
      chk({tag, "/add"}, mem_add_o, add_i[e_w*AW +: AW]);
      chk({tag, "/wen"}, mem_wen_o, wen_i[e_w]);
      chk({tag, "/wdata"}, mem_wdata_o, wdata_i[e_w*DW +: DW]);
      chk({tag, "/be"}, mem_be_o, be_i[e_w*BEW +: BEW]);
      chk({tag, "/winner"}, winner_o, e_w);
    end else begin
      chk({tag, "/winner_idle"}, winner_o, 0);
    end
    if (m_pend && m_pend_rd) chk({tag, "/rdata"}, r_data_o, m_exp_rdata);
    if (xg >= 0) chk({tag, "/plan_gnt"}, gnt_o, xg);
    if (xv >= 0) chk({tag, "/plan_rvalid"}, r_valid_o, xv);
    if (xd >= 0) chk({tag, "/plan_rdata"}, r_data_o, xd);
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    req_i = '0; wen_i = '0; ts_i = '0; mem_gnt_i = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      bank[i] = '0;
      refmem[i] = '0;
    end
    model_reset();

    // Reset state with requests present
    #2;
    req_i = '1; wen_i = '1; mem_gnt_i = 1'b1;
    #1;
    chk("reset/gnt", gnt_o, 0);
    chk("reset/rvalid", r_valid_o, 0);
    chk("reset/mem_req", mem_req_o, 0);
    chk("reset/winner", winner_o, 0);
    do_reset();

    // Round-robin fairness
    arb_policy_i = 1'b0; mem_gnt_i = 1'b1;
    for (int i = 0; i < N; i++) set_rq(i, 1, 1, 0, AW'(i + 1), '0, '1);
    cyc("rr0", 4'b0001, 4'b0000);
    cyc("rr1", 4'b0010, 4'b0001);
    cyc("rr2", 4'b0100, 4'b0010);
    cyc("rr3", 4'b1000, 4'b0100);
    cyc("rr4", 4'b0001, 4'b1000);

    // Fixed priority starves requester 3 and leaves rr_ptr at 0
    do_reset();
    arb_policy_i = 1'b1; mem_gnt_i = 1'b1;
    set_rq(1, 1, 1, 0, 12'h011, '0, '1);
    set_rq(3, 1, 1, 0, 12'h033, '0, '1);
    for (int i = 0; i < 3; i++) cyc("fp", 4'b0010);
    arb_policy_i = 1'b0;
    for (int i = 0; i < N; i++) set_rq(i, 1, 1, 0, AW'(i), '0, '1);
    cyc("fp_ptr0", 4'b0001);

    // Test-and-set with a competing requester
    do_reset();
    mem_gnt_i = 1'b1;
    set_rq(1, 1, 0, 0, 12'h001, 32'h1234_5678, 4'b0011);
    cyc("ts_pre", 4'b0010);
    set_rq(1, 0, 1, 0, '0, '0, '0);
    set_rq(2, 1, 1, 1, 12'h040, '0, '1);
    set_rq(0, 1, 1, 0, 12'h001, '0, '1);
    cyc("ts_c1", 4'b0100);
    set_rq(2, 0, 1, 0, '0, '0, '0);
    cyc("ts_c2", 4'b0000, 4'b0100, 0);
    cyc("ts_c3", 4'b0001);
    set_rq(0, 0, 1, 0, '0, '0, '0);
    set_rq(2, 1, 1, 1, 12'h040, '0, '1);
    cyc("ts2_c1", 4'b0100);
    set_rq(2, 0, 1, 0, '0, '0, '0);
    cyc("ts2_c2", 4'b0000, 4'b0100, 64'hFFFF_FFFF);
    cyc("ts2_idle");

    // Bank stall in IDLE
    do_reset();
    set_rq(0, 1, 1, 0, 12'h002, '0, '1);
    set_rq(1, 1, 1, 0, 12'h003, '0, '1);
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stall", 4'b0000);
    mem_gnt_i = 1'b1;
    cyc("stall_end", 4'b0001);

    // Bank stall during the locked write
    do_reset();
    mem_gnt_i = 1'b1;
    set_rq(1, 1, 1, 1, 12'h010, '0, '1);
    cyc("tss_c1", 4'b0010);
    set_rq(1, 0, 1, 0, '0, '0, '0);
    set_rq(0, 1, 1, 0, 12'h010, '0, '1);
    mem_gnt_i = 1'b0;
    cyc("tss_hold0", 4'b0000, 4'b0010, 0);
    cyc("tss_hold1", 4'b0000, 4'b0000);
    mem_gnt_i = 1'b1;
    cyc("tss_done", 4'b0000);
    cyc("tss_resume", 4'b0001, -1);
    set_rq(0, 0, 1, 0, '0, '0, '0);
    cyc("tss_read", -1, 4'b0001, 64'hFFFF_FFFF);

    // Reset while the locked write is pending
    set_rq(3, 1, 1, 1, 12'h080, '0, '1);
    cyc("rts_c1", 4'b1000);
    set_rq(3, 0, 1, 0, '0, '0, '0);
    set_rq(0, 1, 1, 0, 12'h005, '0, '1);
    rst_ni = 1'b0;
    #1;
    chk("rts/gnt", gnt_o, 0);
    chk("rts/rvalid", r_valid_o, 0);
    chk("rts/mem_req", mem_req_o, 0);
    chk("rts/winner", winner_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) set_rq(i, 1, 1, 0, 12'h080, '0, '1);
    cyc("rts_ptr0", 4'b0001);
    req_i = '0;
    cyc("rts_nowrite", -1, 4'b0001, 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) arb_policy_i = 1'($urandom_range(0, 1));
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        int sel;
        logic [AW-1:0] a;
        sel = $urandom_range(0, 9);
        a = (sel < 8) ? AW'(sel) : ((sel == 8) ? 12'h040 : 12'h080);
        set_rq(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), a, $urandom, BEW'($urandom));
      end
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hci_bank_ts_arbiter.md
Name: hci_bank_ts_arbiter

Overview:
Per-bank arbiter and sequencer that shares one single-port TCDM memory bank between N_REQ HCI-style requesters. It selects one request per cycle, either round-robin or fixed-priority, and routes the 1-cycle-latency response back to the granted requester. It also executes atomic test-and-set: the original read is followed by a locked all-ones write to the same word. It sits between the log-interconnect output for one bank and the SRAM bank wrapper.

Parameters:
N_REQ, 4, number of requesters (>=2)
AW, 12, bank word-address width
DW, 32, data width (bits)
BW, 8, byte width; byte-enable width is DW/BW
IW, 2, width of the winner index output, equal to clog2(N_REQ)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
arb_policy_i  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
req_i  in  N_REQ  request per requester
add_i  in  N_REQ*AW  word address per requester
wen_i  in  N_REQ  1 = read, 0 = write
wdata_i  in  N_REQ*DW  write data
be_i  in  N_REQ*DW/BW  byte enables
ts_i  in  N_REQ  test-and-set qualifier (meaningful only with wen=1)
gnt_o  out  N_REQ  one-hot grant
r_valid_o  out  N_REQ  one-hot response valid
r_data_o  out  DW  response data, shared by all requesters
mem_req_o  out  1  bank request
mem_add_o  out  AW  bank address
mem_wen_o  out  1  bank read/write (1 = read)
mem_wdata_o  out  DW  bank write data
mem_be_o  out  DW/BW  bank byte enables
mem_gnt_i  in  1  bank accepts this cycle
mem_r_data_i  in  DW  bank read data, valid 1 cycle after an accepted read
winner_o  out  IW  index of the current winner (debug/trace)

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, resp_pending=0, gnt_o=0, r_valid_o=0, mem_req_o=0, winner_o=0. Reset asserted mid-TS drops the pending write; no response is produced.
- Arbitration (combinational, evaluated in IDLE only):
  - Round-robin: winner = first asserted req_i at or after rr_ptr, wrapping from N_REQ-1 to 0.
  - Fixed priority: winner = lowest asserted index.
- IDLE:
  - If any req_i is asserted, drive mem_* from the winner's request with mem_req_o=1.
  - gnt_o[winner] = mem_gnt_i. No other gnt bit may be high.
  - On a handshake (req & gnt), in round-robin mode set rr_ptr <= (winner+1) mod N_REQ. In fixed-priority mode rr_ptr is unchanged.
  - If the handshake is a TS read (ts_i[w]=1, wen_i[w]=1), latch the address and go to TS_WR.
  - A ts_i with wen=0 is a plain write.
- TS_WR:
  - Drive mem_req_o=1, mem_wen_o=0, mem_add_o=latched address, mem_wdata_o=all ones, mem_be_o=all ones.
  - gnt_o=0 for every requester, so the bank is locked.
  - Stay in TS_WR until mem_gnt_i=1, then return to IDLE. The next arbitration begins in the following cycle.
- Response:
  - Every handshake (read or write) registers the winner index; r_valid_o[that index]=1 exactly one cycle later.
  - r_data_o = mem_r_data_i in that cycle; its value is don't-care for writes.
  - The TS write produces no r_valid. The TS read's r_valid coincides with the first TS_WR cycle and returns the old value.
- Back-to-back handshakes are allowed every cycle in IDLE; r_valid follows each one in lockstep.
- With mem_gnt_i=0 in IDLE: no grant, rr_ptr holds, and the winner may change next cycle if req_i changes.
- A requester must hold its request until granted. A dropped request is simply not served.

Test Plan:
1. Round-robin fairness: all 4 req_i held high, mem_gnt_i=1, policy=0 -> gnt_o sequence 0001, 0010, 0100, 1000, 0001; r_valid_o repeats the same sequence delayed by 1 cycle.
2. Fixed priority: req_i=1010, policy=1, mem_gnt_i=1 for 3 cycles -> gnt_o=0010 every cycle; requester 3 starves; rr_ptr stays 0.
3. Test-and-set:
   - Stimulus: memory word 0x040 = 0x0000_0000; requester 2 issues a TS read to 0x040 while requester 0 also requests.
   - Cycle 1: gnt_o=0100.
   - Cycle 2: mem_wen_o=0, mem_add_o=0x040, mem_wdata_o=0xFFFF_FFFF, gnt_o=0000, r_valid_o=0100, r_data_o=0x0.
   - Cycle 3: gnt_o=0001.
   - A second TS read to 0x040 returns 0xFFFF_FFFF.
4. Bank stall: mem_gnt_i=0 for 3 cycles with req_i=0011, policy=0 -> gnt_o=0 and rr_ptr=0 throughout; on the first cycle with mem_gnt_i=1, gnt_o=0001.
5. Stall during TS: mem_gnt_i=0 for 2 cycles while in TS_WR -> the write is held stable and no grants are issued; with mem_gnt_i=1 the write completes and IDLE resumes next cycle.
6. Reset mid-TS: assert rst_ni=0 while in TS_WR -> all outputs 0 immediately; after release, state=IDLE and rr_ptr=0.
